// File: rtl/prio_flag_pkg.sv
// prio_flag_pkg
// Shared types and helpers for the priority-pointer generator.
//   prio_policy_e : run-time arbitration policy encoding
//   wrap_inc      : increment that wraps at an arbitrary modulus n, so
//                   non-power-of-two master counts never land on an
//                   index that has no master behind it
package prio_flag_pkg;

  typedef enum logic [1:0] {
    PRIO_RR       = 2'b00,
    PRIO_LAST_WIN = 2'b01,
    PRIO_FIXED    = 2'b10,
    PRIO_RSVD     = 2'b11
  } prio_policy_e;

  function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned n);
    return (p + 1 >= n) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/prio_next_enabled.sv
// prio_next_enabled
// Combinational masked circular search: returns the first enabled index
// after base_i, wrapping at N_MASTERS-1 back to 0. Returns base_i when
// no other index is enabled (covers the lone-enabled and all-zero masks).
// Ports:
//   base_i    in  WIDTH      search start (excluded from the first pass)
//   en_mask_i in  N_MASTERS  eligibility mask
//   nxt_o     out WIDTH      next enabled index
module prio_next_enabled
  import prio_flag_pkg::*;
#(
  parameter int N_MASTERS = 6,
  parameter int WIDTH     = $clog2(N_MASTERS)
) (
  input  logic [WIDTH-1:0]     base_i,
  input  logic [N_MASTERS-1:0] en_mask_i,
  output logic [WIDTH-1:0]     nxt_o
);

  logic [WIDTH-1:0] idx;
  logic             found;

  // N_MASTERS steps: the last step returns to base_i itself, so a base
  // that is the only enabled master selects itself.
  always_comb begin
    nxt_o = base_i;
    found = 1'b0;
    idx   = base_i;
    for (int i = 0; i < N_MASTERS; i++) begin
      idx = WIDTH'(wrap_inc(32'(idx), N_MASTERS));
      if (!found && en_mask_i[idx]) begin
        nxt_o = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_flag_gen.sv
// prio_flag_gen
// Registered priority pointer for the Log-XBar arbitration trees. The flag
// moves only on a completed req/gnt handshake, under one of three policies:
// round-robin, last-winner demotion, or fixed (flag to 0).
// Optional feature macro: PRIO_WEIGHT_EN (weighted round-robin with a
// per-master credit counter and a weight_i input port).
// Ports:
//   clk          in  1                    clock
//   rst          in  1                    async active-high reset
//   arb_policy_i in  2                    00 RR, 01 LAST_WIN, 10 FIXED, 11 RR
//   en_mask_i    in  N_MASTERS            per-master eligibility
//   data_req_i   in  1                    request at tree root
//   data_gnt_i   in  1                    grant at tree root
//   id_i         in  WIDTH                winning master of the handshake
//   weight_i     in  N_MASTERS*WEIGHT_W   RR weights (PRIO_WEIGHT_EN only)
//   prio_flag_o  out WIDTH                registered priority flag
//   flag_upd_o   out 1                    flag changed in previous cycle
module prio_flag_gen
  import prio_flag_pkg::*;
#(
  parameter int N_MASTERS = 6,
  parameter int WIDTH     = $clog2(N_MASTERS),
  parameter int WEIGHT_W  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    arb_policy_i,
  input  logic [N_MASTERS-1:0]          en_mask_i,
  input  logic                          data_req_i,
  input  logic                          data_gnt_i,
  input  logic [WIDTH-1:0]              id_i,
`ifdef PRIO_WEIGHT_EN
  input  logic [N_MASTERS*WEIGHT_W-1:0] weight_i,
`endif
  output logic [WIDTH-1:0]              prio_flag_o,
  output logic                          flag_upd_o
);

  logic              hs;
  logic              pol_chg;
  logic [1:0]        policy_q;
  prio_policy_e      policy;
  logic [WIDTH-1:0]  nxt_flag;
  logic [WIDTH-1:0]  nxt_id;
  logic [WIDTH-1:0]  flag_d;
  logic              rr_adv;

  assign hs      = data_req_i & data_gnt_i;
  assign policy  = prio_policy_e'(arb_policy_i);
  assign pol_chg = (arb_policy_i != policy_q);

  prio_next_enabled #(.N_MASTERS(N_MASTERS), .WIDTH(WIDTH)) u_nxt_flag (
    .base_i    (prio_flag_o),
    .en_mask_i (en_mask_i),
    .nxt_o     (nxt_flag)
  );

  prio_next_enabled #(.N_MASTERS(N_MASTERS), .WIDTH(WIDTH)) u_nxt_id (
    .base_i    (id_i),
    .en_mask_i (en_mask_i),
    .nxt_o     (nxt_id)
  );

`ifdef PRIO_WEIGHT_EN
  logic [WEIGHT_W-1:0] credit_q;
  logic [WEIGHT_W-1:0] credit_eff;
  logic [WEIGHT_W-1:0] credit_d;
  logic [WEIGHT_W-1:0] w_cur;

  // A policy change clears the credit in the same cycle, so a coincident
  // RR handshake counts from zero.
  assign credit_eff = pol_chg ? '0 : credit_q;

  always_comb begin
    w_cur = weight_i[32'(prio_flag_o)*WEIGHT_W +: WEIGHT_W];
    if (w_cur == '0) w_cur = WEIGHT_W'(1);
  end

  assign rr_adv = ({1'b0, credit_eff} + (WEIGHT_W+1)'(1)) >= {1'b0, w_cur};

  always_comb begin
    credit_d = credit_eff;
    if (policy == PRIO_LAST_WIN || policy == PRIO_FIXED) begin
      credit_d = '0;
    end else if (hs) begin
      credit_d = rr_adv ? '0 : credit_eff + WEIGHT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) credit_q <= '0;
    else     credit_q <= credit_d;
  end
`else
  assign rr_adv = 1'b1;
`endif

  always_comb begin
    flag_d = prio_flag_o;
    if (hs) begin
      case (policy)
        PRIO_FIXED:    flag_d = '0;
        // Out-of-range winner IDs carry no usable position; hold.
        PRIO_LAST_WIN: if (32'(id_i) < N_MASTERS) flag_d = nxt_id;
        default:       if (rr_adv) flag_d = nxt_flag;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_flag_o <= '0;
      flag_upd_o  <= 1'b0;
      policy_q    <= 2'b00;
    end else begin
      prio_flag_o <= flag_d;
      flag_upd_o  <= (flag_d != prio_flag_o);
      policy_q    <= arb_policy_i;
    end
  end

endmodule

// File: tb/tb_prio_flag_gen.sv
module tb_prio_flag_gen;
  import prio_flag_pkg::*;

  localparam int N_MASTERS = 6;
  localparam int WIDTH     = $clog2(N_MASTERS);
  localparam int WEIGHT_W  = 3;

  logic                          clk;
  logic                          rst;
  logic [1:0]                    arb_policy_i;
  logic [N_MASTERS-1:0]          en_mask_i;
  logic                          data_req_i;
  logic                          data_gnt_i;
  logic [WIDTH-1:0]              id_i;
`ifdef PRIO_WEIGHT_EN
  logic [N_MASTERS*WEIGHT_W-1:0] weight_i;
`endif
  logic [WIDTH-1:0]              prio_flag_o;
  logic                          flag_upd_o;

  int n_pass = 0;
  int n_total = 0;

  prio_flag_gen #(.N_MASTERS(N_MASTERS), .WIDTH(WIDTH), .WEIGHT_W(WEIGHT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .arb_policy_i (arb_policy_i),
    .en_mask_i    (en_mask_i),
    .data_req_i   (data_req_i),
    .data_gnt_i   (data_gnt_i),
    .id_i         (id_i),
`ifdef PRIO_WEIGHT_EN
    .weight_i     (weight_i),
`endif
    .prio_flag_o  (prio_flag_o),
    .flag_upd_o   (flag_upd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Drive handshake inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic req, input logic gnt, input int id);
    data_req_i = req;
    data_gnt_i = gnt;
    id_i       = WIDTH'(id);
    @(posedge clk);
    #1;
  endtask

  int exp_rr[7]   = '{1, 2, 3, 4, 5, 0, 1};
  int exp_skip[3] = '{2, 5, 0};
`ifdef PRIO_WEIGHT_EN
  int exp_w[5]    = '{0, 0, 1, 2, 3};
`endif

  initial begin
    rst          = 1'b1;
    arb_policy_i = 2'b00;
    en_mask_i    = 6'h3F;
    data_req_i   = 1'b0;
    data_gnt_i   = 1'b0;
    id_i         = '0;
`ifdef PRIO_WEIGHT_EN
    for (int k = 0; k < N_MASTERS; k++) weight_i[k*WEIGHT_W +: WEIGHT_W] = 3'd1;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_flag", int'(prio_flag_o), 0);
    check("reset_upd", int'(flag_upd_o), 0);
    rst = 1'b0;
    step(1'b0, 1'b0, 0);
    check("idle_flag", int'(prio_flag_o), 0);

    // Round-robin wrap at N_MASTERS-1
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, 0);
      check($sformatf("rr_wrap_flag[%0d]", i), int'(prio_flag_o), exp_rr[i]);
      check($sformatf("rr_wrap_upd[%0d]", i), int'(flag_upd_o), 1);
    end
    step(1'b0, 1'b0, 0);
    check("rr_hold_flag", int'(prio_flag_o), 1);
    check("rr_hold_upd", int'(flag_upd_o), 0);
    step(1'b1, 1'b0, 0);
    check("req_no_gnt_flag", int'(prio_flag_o), 1);

    // FIXED brings flag to 0, then masked skip in RR
    arb_policy_i = 2'b10;
    step(1'b1, 1'b1, 0);
    check("fixed_to_zero", int'(prio_flag_o), 0);
    arb_policy_i = 2'b00;
    en_mask_i    = 6'b100101;
    step(1'b0, 1'b0, 0);
    check("mask_change_only", int'(prio_flag_o), 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 0);
      check($sformatf("skip_flag[%0d]", i), int'(prio_flag_o), exp_skip[i]);
    end
    en_mask_i = '0;
    step(1'b1, 1'b1, 0);
    check("mask0_flag", int'(prio_flag_o), 0);
    check("mask0_upd", int'(flag_upd_o), 0);

    // Policy 11 behaves as RR
    en_mask_i    = 6'h3F;
    arb_policy_i = 2'b11;
    step(1'b1, 1'b1, 0);
    check("rsvd_as_rr", int'(prio_flag_o), 1);

    // LAST_WIN demotes the winner; out-of-range ID holds
    arb_policy_i = 2'b01;
    step(1'b1, 1'b1, 4);
    check("lastwin_id4", int'(prio_flag_o), 5);
    step(1'b1, 1'b1, 5);
    check("lastwin_id5", int'(prio_flag_o), 0);
    check("lastwin_id5_upd", int'(flag_upd_o), 1);
    step(1'b1, 1'b1, 7);
    check("lastwin_id7", int'(prio_flag_o), 0);
    check("lastwin_id7_upd", int'(flag_upd_o), 0);

    // Set flag to 3, switch to FIXED with no traffic, then one handshake
    step(1'b1, 1'b1, 2);
    check("lastwin_id2", int'(prio_flag_o), 3);
    arb_policy_i = 2'b10;
    step(1'b0, 1'b0, 0);
    check("polchg_idle0", int'(prio_flag_o), 3);
    step(1'b0, 1'b0, 0);
    check("polchg_idle1", int'(prio_flag_o), 3);
    check("polchg_idle_upd", int'(flag_upd_o), 0);
    step(1'b1, 1'b1, 0);
    check("fixed_hs_flag", int'(prio_flag_o), 0);
    check("fixed_hs_upd", int'(flag_upd_o), 1);
    step(1'b0, 1'b0, 0);
    check("fixed_after_upd", int'(flag_upd_o), 0);

    // Async reset in the middle of back-to-back handshakes at flag=4
    arb_policy_i = 2'b00;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 0);
    check("pre_reset_flag", int'(prio_flag_o), 4);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_flag", int'(prio_flag_o), 0);
    check("async_rst_upd", int'(flag_upd_o), 0);
    step(1'b0, 1'b0, 0);
    rst = 1'b0;
    step(1'b1, 1'b1, 0);
    check("post_rst_flag", int'(prio_flag_o), 1);
    check("post_rst_upd", int'(flag_upd_o), 1);

`ifdef PRIO_WEIGHT_EN
    // Weighted RR: m0=3, m1=0 (acts as 1), others 1
    step(1'b0, 1'b0, 0);
    rst = 1'b1;
    step(1'b0, 1'b0, 0);
    rst = 1'b0;
    weight_i[0*WEIGHT_W +: WEIGHT_W] = 3'd3;
    weight_i[1*WEIGHT_W +: WEIGHT_W] = 3'd0;
    step(1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 0);
      check($sformatf("weighted_flag[%0d]", i), int'(prio_flag_o), exp_w[i]);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
